// File: rtl/ship_life_ctl.sv
// Ship life-cycle controller: hit -> explode -> respawn -> invulnerable blink -> clear latch.
// Tracks remaining lives and holds game over until reset.
module ship_life_ctl #(
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned EXPLODE_FRAMES = 32,
  parameter int unsigned BLINK_FRAMES   = 64,
  parameter int unsigned BLINK_HALF     = 4
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       hit_locked,
  input  logic       vsync,
  output logic       unlock,
  output logic [1:0] lives,
  output logic       ship_visible,
  output logic       ctrl_enable,
  output logic       respawn,
  output logic       game_over
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned VIS_BIT = $clog2(BLINK_HALF);

  typedef enum logic [2:0] {
    ST_ALIVE     = 3'd0,
    ST_EXPLODE   = 3'd1,
    ST_RESPAWN   = 3'd2,
    ST_BLINK     = 3'd3,
    ST_CLEAR     = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         lives_q, lives_d;
  logic               vs_q;
  logic               unlock_q, unlock_d;
  logic               vis_q, vis_d;
  logic               ctrl_q, ctrl_d;
  logic               resp_q, resp_d;
  logic               go_q, go_d;
  logic               tick_c;
  logic [CNT_W-1:0]   cnt_inc_c;

  assign tick_c    = vsync & ~vs_q;
  assign cnt_inc_c = cnt_q + CNT_W'(1);

  // State, counter, lives and registered outputs
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q  <= ST_ALIVE;
      cnt_q    <= '0;
      lives_q  <= 2'(LIVES_INIT);
      vs_q     <= 1'b0;
      unlock_q <= 1'b0;
      vis_q    <= 1'b1;
      ctrl_q   <= 1'b1;
      resp_q   <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lives_q  <= lives_d;
      vs_q     <= vsync;
      unlock_q <= unlock_d;
      vis_q    <= vis_d;
      ctrl_q   <= ctrl_d;
      resp_q   <= resp_d;
      go_q     <= go_d;
    end
  end

  // Next state, then outputs decoded from the state being entered
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lives_d  = lives_q;
    unlock_d = 1'b0;
    vis_d    = 1'b1;
    ctrl_d   = 1'b1;
    resp_d   = 1'b0;
    go_d     = 1'b0;

    case (state_q)
      ST_ALIVE: begin
        if (hit_locked) begin
          state_d = ST_EXPLODE;
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
        end
      end
      ST_EXPLODE: begin
        if (tick_c) begin
          if (cnt_inc_c == CNT_W'(EXPLODE_FRAMES)) begin
            state_d = (lives_q == 2'd0) ? ST_GAME_OVER : ST_RESPAWN;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
      end
      ST_RESPAWN: state_d = ST_BLINK;
      ST_BLINK: begin
        if (tick_c) begin
          if (cnt_inc_c == CNT_W'(BLINK_FRAMES)) begin
            state_d = ST_CLEAR;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
      end
      ST_CLEAR: begin
        if (!hit_locked) begin
          state_d = ST_ALIVE;
        end
      end
      ST_GAME_OVER: state_d = ST_GAME_OVER;
      default: state_d = ST_ALIVE;
    endcase

    // Any state change restarts the frame count, swallowing a tick on the entry edge
    if (state_d != state_q) begin
      cnt_d = '0;
    end

    case (state_d)
      ST_EXPLODE: begin
        vis_d  = 1'b0;
        ctrl_d = 1'b0;
      end
      ST_RESPAWN: begin
        resp_d = 1'b1;
        vis_d  = 1'b0;
        ctrl_d = 1'b0;
      end
      ST_BLINK: vis_d = ~cnt_d[VIS_BIT];
      ST_CLEAR: unlock_d = 1'b1;
      ST_GAME_OVER: begin
        go_d   = 1'b1;
        vis_d  = 1'b0;
        ctrl_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign unlock       = unlock_q;
  assign lives        = lives_q;
  assign ship_visible = vis_q;
  assign ctrl_enable  = ctrl_q;
  assign respawn      = resp_q;
  assign game_over    = go_q;

endmodule

// File: tb/tb_ship_life_ctl.sv
// Directed bench for ship_life_ctl: expected outputs queued with each step and popped after the edge.
module tb_ship_life_ctl;

  typedef struct packed {
    logic       unlock;
    logic [1:0] lives;
    logic       vis;
    logic       ctrl;
    logic       resp;
    logic       go;
  } exp_t;

  logic       pclk = 1'b0;
  logic       rst, hit_locked, vsync;
  logic       unlock, ship_visible, ctrl_enable, respawn, game_over;
  logic [1:0] lives;

  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;

  exp_t  sb_q[$];
  string tag_q[$];

  ship_life_ctl #(
    .LIVES_INIT(3), .EXPLODE_FRAMES(4), .BLINK_FRAMES(8), .BLINK_HALF(2)
  ) dut (
    .pclk(pclk), .rst(rst), .hit_locked(hit_locked), .vsync(vsync),
    .unlock(unlock), .lives(lives), .ship_visible(ship_visible),
    .ctrl_enable(ctrl_enable), .respawn(respawn), .game_over(game_over)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (respawn === 1'b1) resp_cnt++;
  end

  task automatic cyc(input logic v);
    vsync = v;
    @(posedge pclk);
    #1;
  endtask

  // One display frame: a low sample then a high sample, giving one tick
  task automatic frame();
    cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic expect_o(input string tag, input logic u, input logic [1:0] l,
                          input logic v, input logic c, input logic r, input logic g);
    exp_t e;
    e = '{unlock: u, lives: l, vis: v, ctrl: c, resp: r, go: g};
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_o();
    exp_t  e, obs;
    string t;
    e   = sb_q.pop_front();
    t   = tag_q.pop_front();
    obs = {unlock, lives, ship_visible, ctrl_enable, respawn, game_over};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b (unlock,lives[1:0],vis,ctrl,resp,go)", t, obs, e);
    end
  endtask

  task automatic chk(input string tag, input logic u, input logic [1:0] l,
                     input logic v, input logic c, input logic r, input logic g);
    expect_o(tag, u, l, v, c, r, g);
    check_o();
  endtask

  task automatic chk_resp(input string tag, input int exp_n);
    checks++;
    assert (resp_cnt === exp_n) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, resp_cnt, exp_n);
    end
  endtask

  // Full hit sequence; la is the life count after the hit
  task automatic life_seq(input logic [1:0] la);
    hit_locked = 1'b1;
    cyc(1'b0);
    chk("hit", 1'b0, la, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      frame();
      chk("explode", 1'b0, la, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    frame();
    if (la != 2'd0) begin
      chk("respawn", 1'b0, la, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0);
      chk("blink0", 1'b0, la, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 7; k++) begin
        frame();
        chk("blink", 1'b0, la, logic'(((k / 2) % 2) == 0), 1'b1, 1'b0, 1'b0);
      end
      frame();
      chk("clear", 1'b1, la, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        cyc(1'b0);
        chk("clear_hold", 1'b1, la, 1'b1, 1'b1, 1'b0, 1'b0);
      end
      hit_locked = 1'b0;
      cyc(1'b0);
      chk("alive", 1'b0, la, 1'b1, 1'b1, 1'b0, 1'b0);
    end else begin
      chk("game_over", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1;
    hit_locked = 1'b0;
    vsync = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    chk("reset", 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      frame();
      chk("idle", 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    chk_resp("idle_resp", 0);

    life_seq(2'd2);
    chk_resp("resp_after_1", 1);
    life_seq(2'd1);
    chk_resp("resp_after_2", 2);
    life_seq(2'd0);
    for (int i = 0; i < 20; i++) begin
      frame();
      chk("go_hold", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk_resp("resp_after_go", 2);

    rst = 1'b1;
    hit_locked = 1'b0;
    cyc(1'b0);
    chk("reset_go", 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b0);

    // Hit and tick together: the tick must not be counted
    hit_locked = 1'b1;
    cyc(1'b1);
    chk("hit_tick", 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      frame();
      chk("explode2", 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    frame();
    chk("respawn2", 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0);
    for (int k = 1; k <= 5; k++) begin
      frame();
      chk("blink2", 1'b0, 2'd2, logic'(((k / 2) % 2) == 0), 1'b1, 1'b0, 1'b0);
    end
    rst = 1'b1;
    hit_locked = 1'b0;
    cyc(1'b1);
    chk("reset_blink", 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      frame();
      chk("post_reset", 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    chk_resp("resp_final", 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ship_life_ctl.md
SHIP_LIFE_CTL -- requirements
Module: ship_life_ctl

Interface
REQ-001 Parameter LIVES_INIT, default 3: lives loaded at reset; legal range 1..3.
REQ-002 Parameter EXPLODE_FRAMES, default 32: frame ticks spent in EXPLODE; legal range 1..255.
REQ-003 Parameter BLINK_FRAMES, default 64: frame ticks spent in BLINK; legal range 1..255.
REQ-004 Parameter BLINK_HALF, default 4: frame ticks per visible/invisible phase in BLINK; power of 2, 1..128.
REQ-005 pclk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 hit_locked  in  1  latched ship-hit flag from the upstream hit latch; stays high until cleared via unlock.
REQ-008 vsync  in  1  frame sync from the display timing; level signal.
REQ-009 unlock  out  1  clear request to the upstream hit latch.
REQ-010 lives  out  2  remaining lives, unsigned.
REQ-011 ship_visible  out  1  1 = draw ship.
REQ-012 ctrl_enable  out  1  1 = player movement and fire enabled.
REQ-013 respawn  out  1  single-cycle pulse: return ship to start position.
REQ-014 game_over  out  1  1 = no lives left; sticky.

Function
REQ-015 Frame tick = vsync high AND vsync registered one cycle earlier low. One cycle per rising vsync edge.
REQ-016 All outputs are registered and change on the same edge as the state register they belong to.
REQ-017 States: ALIVE, EXPLODE, RESPAWN, BLINK, CLEAR, GAME_OVER. The encoding is free.
REQ-018 8-bit frame counter: cleared on every state entry; increments on each tick while in EXPLODE or BLINK. A tick coinciding with the entry edge is not counted.
REQ-019 ALIVE: ship_visible=1, ctrl_enable=1, unlock=0.
  - hit_locked=1 sampled -> EXPLODE at the next edge.
  - lives decrements on that same edge, saturating at 0.
REQ-020 EXPLODE: ship_visible=0, ctrl_enable=0.
  - On the tick that makes the count equal EXPLODE_FRAMES, go to GAME_OVER if lives==0, else to RESPAWN.
REQ-021 RESPAWN: lasts exactly one cycle; respawn=1, ship_visible=0, ctrl_enable=0; then BLINK.
REQ-022 BLINK: ctrl_enable=1; hit_locked ignored (ship invulnerable).
  - ship_visible=1 when floor(count/BLINK_HALF) is even, else 0.
  - On the tick that makes the count equal BLINK_FRAMES -> CLEAR.
REQ-023 CLEAR: unlock=1, ship_visible=1, ctrl_enable=1.
  - Go to ALIVE on the first edge where hit_locked=0 is sampled.
  - unlock deasserts on that same edge.
  - CLEAR has no timeout.
REQ-024 GAME_OVER: game_over=1, ship_visible=0, ctrl_enable=0, unlock=0, lives=0. The state is left only by rst.
REQ-025 respawn is high only in RESPAWN; it is never high for two consecutive cycles.
REQ-026 hit_locked is ignored in every state except ALIVE. A hit latched during EXPLODE or BLINK costs no extra life.
REQ-027 hit_locked and a tick on the same ALIVE cycle: the hit is taken; the tick is not counted.
REQ-028 lives changes only on the ALIVE->EXPLODE edge and on reset.

Reset
REQ-029 rst=1 at an edge forces, on that edge, regardless of state or inputs:
  - state ALIVE, lives=LIVES_INIT;
  - ship_visible=1, ctrl_enable=1;
  - unlock=0, respawn=0, game_over=0;
  - frame counter=0, vsync history=0.
REQ-030 rst has priority over every other input. Reset during EXPLODE, BLINK or CLEAR abandons the sequence with no respawn pulse.
REQ-031 The first vsync edge after reset is counted as a tick only if vsync was sampled low at least once after reset.

Verification
Bench parameters: EXPLODE_FRAMES=4, BLINK_FRAMES=8, BLINK_HALF=2, LIVES_INIT=3.
REQ-032 Reset, hold hit_locked=0, drive 10 vsync pulses -> lives=3, ship_visible=1, ctrl_enable=1, unlock=0, respawn=0 throughout.
REQ-033 Single hit: hit_locked=1 in ALIVE ->
  - next edge: lives=2, ship_visible=0, ctrl_enable=0;
  - after 4 ticks: one respawn pulse;
  - BLINK visibility pattern per tick pair: 1,0,1,0;
  - after 8 BLINK ticks: unlock=1 until hit_locked is dropped, then ALIVE with unlock=0.
REQ-034 Three hits, each after a full sequence -> lives 2,1,0. After the third EXPLODE (4 ticks): game_over=1, no respawn pulse, unlock stays 0 through 20 further ticks.
REQ-035 Keep hit_locked=1 for 3 cycles after unlock rises -> state stays CLEAR, unlock stays high. hit_locked=0 -> ALIVE next edge, lives unchanged.
REQ-036 Assert rst mid-BLINK (tick 5) -> next edge: lives=3, ship_visible=1, ctrl_enable=1, unlock=0. No respawn pulse follows.
